// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame constants and FSM states.
package imem_loader_pkg;

  localparam logic [7:0] LDR_MAGIC = 8'hA5;
  localparam int         LDR_LEN_W = 16;

  typedef enum logic [2:0] {
    LDR_SYNC = 3'd0,
    LDR_LEN0 = 3'd1,
    LDR_LEN1 = 3'd2,
    LDR_DATA = 3'd3,
    LDR_CSUM = 3'd4,
    LDR_DONE = 3'd5,
    LDR_ERR  = 3'd6
  } ldr_state_e;

  // The loader takes bytes in every state except the two terminal ones.
  function automatic logic ldr_accepting(input ldr_state_e s);
    return (s != LDR_DONE) && (s != LDR_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [31:0]           imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words.
// word_o already contains the byte being accepted, so the loader can latch the
// complete word on the same edge that word_done_o is high.
module imem_loader_word_packer (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;

  // Next lane / merge the incoming byte into its lane.
  always_comb begin
    lane_d      = lane_q;
    word_d      = word_q;
    word_done_o = 1'b0;
    if (clear_i) begin
      lane_d = 2'd0;
      word_d = 32'd0;
    end else if (byte_valid_i) begin
      word_d[8*lane_q +: 8] = byte_i;
      lane_d                = lane_q + 2'd1;
      word_done_o           = (lane_q == 2'd3);
    end
  end

  assign word_o = word_d;

  // Lane counter and partial-word register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      lane_q <= 2'd0;
      word_q <= 32'd0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses MAGIC/LEN/payload/CSUM frames, writes the
// payload words into imem and keeps the core in reset until a frame loads cleanly.
//
// state | meaning
// SYNC  | hunting for the MAGIC sync byte, other bytes dropped
// LEN0  | capture LEN low byte
// LEN1  | capture LEN high byte, range-check LEN
// DATA  | payload bytes, one imem write per 4 bytes
// CSUM  | compare received byte with running XOR of payload
// DONE  | frame loaded, core released, stream stalled
// ERR   | bad length or checksum, core held, stream stalled
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] MAGIC      = LDR_MAGIC
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                reload_i,
  imem_loader_if.master       bus,
  output logic                system_active,
  output logic                core_rst,
  output logic                load_err,
  output logic [ADDR_WIDTH:0] words_loaded
);

  localparam logic [31:0] CAPACITY = 32'(1) << ADDR_WIDTH;

  ldr_state_e            state_q, state_d;
  logic [LDR_LEN_W-1:0]  len_q, len_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [7:0]            xor_q, xor_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic                  rx_ready;
  logic                  accept;
  logic                  word_done;
  logic [31:0]           packed_word;
  logic [LDR_LEN_W-1:0]  len_full;
  logic [ADDR_WIDTH:0]   words_inc;

  assign rx_ready  = ldr_accepting(state_q);
  assign accept    = bus.rx_valid & rx_ready;
  assign len_full  = {bus.rx_data, len_q[7:0]};
  assign words_inc = words_q + 1'b1;

  // Lane state is only meaningful inside DATA, so it is forced clear elsewhere.
  imem_loader_word_packer u_packer (
    .clk          (clk),
    .rst_i        (rst_i),
    .clear_i      (state_q != LDR_DATA),
    .byte_valid_i (accept && (state_q == LDR_DATA)),
    .byte_i       (bus.rx_data),
    .word_done_o  (word_done),
    .word_o       (packed_word)
  );

  // Frame FSM, length/word counters, checksum and imem write staging.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    xor_d   = xor_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    case (state_q)
      LDR_SYNC: begin
        if (accept && (bus.rx_data == MAGIC)) state_d = LDR_LEN0;
      end

      LDR_LEN0: begin
        if (accept) begin
          len_d[7:0] = bus.rx_data;
          state_d    = LDR_LEN1;
        end
      end

      LDR_LEN1: begin
        if (accept) begin
          len_d = len_full;
          // Anything larger than the memory would wrap the word address.
          if (32'(len_full) > CAPACITY) begin
            state_d = LDR_ERR;
            err_d   = 1'b1;
          end else if (len_full == '0) begin
            state_d = LDR_CSUM;
          end else begin
            state_d = LDR_DATA;
          end
        end
      end

      LDR_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ bus.rx_data;
          if (word_done) begin
            we_d    = 1'b1;
            waddr_d = words_q[ADDR_WIDTH-1:0];
            wdata_d = packed_word;
            words_d = words_inc;
            if (LDR_LEN_W'(words_inc) == len_q) state_d = LDR_CSUM;
          end
        end
      end

      LDR_CSUM: begin
        if (accept) begin
          if (bus.rx_data == xor_q) begin
            state_d = LDR_DONE;
          end else begin
            state_d = LDR_ERR;
            err_d   = 1'b1;
          end
        end
      end

      LDR_DONE, LDR_ERR: begin
        if (reload_i) begin
          state_d = LDR_SYNC;
          err_d   = 1'b0;
          words_d = '0;
          xor_d   = 8'd0;
        end
      end

      default: state_d = LDR_SYNC;
    endcase
  end

  // State and datapath registers; reset also drops a write staged on this edge.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= LDR_SYNC;
      len_q   <= '0;
      words_q <= '0;
      xor_q   <= 8'd0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      xor_q   <= xor_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign system_active  = (state_q == LDR_DONE);
  assign core_rst       = (state_q != LDR_DONE);
  assign load_err       = err_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard and an imem model.
module tb_imem_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          reload_i;
  logic          system_active;
  logic          core_rst;
  logic          load_err;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .reload_i      (reload_i),
    .bus           (bus.master),
    .system_active (system_active),
    .core_rst      (core_rst),
    .load_err      (load_err),
    .words_loaded  (words_loaded)
  );

  always #5 clk = ~clk;

  int            errors   = 0;
  int            checks   = 0;
  int            wr_count = 0;
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW+31:0] exp_q [$];
  logic [7:0]    pay_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // imem model plus scoreboard pop on every write strobe.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      logic [AW+31:0] e;
      wr_count++;
      mem[bus.imem_waddr] = bus.imem_wdata;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=%0h data=%0h, expected no write",
               bus.imem_waddr, bus.imem_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", 64'(bus.imem_waddr), 64'(e[AW+31:32]));
        check("write_data", 64'(bus.imem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (bus.rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL rx_ready_stall: observed=%0b expected=1 (byte %02h)", bus.rx_ready, b);
      bus.rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  // Sends the first n payload bytes, pushing every completed word as an expectation.
  task automatic send_pay(input int n, input bit gaps);
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < n; k++) begin
      acc[8*(k%4) +: 8] = pay_q[k];
      if (k % 4 == 3) exp_q.push_back({AW'(k / 4), acc});
      send_byte(pay_q[k], gaps);
    end
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload_i = 1'b1;
    @(negedge clk);
    reload_i = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] len, input bit corrupt, input bit gaps,
                            input bit reload_mid);
    logic [7:0] cs;
    cs = 8'd0;
    foreach (pay_q[i]) cs ^= pay_q[i];
    if (corrupt) cs ^= 8'h01;
    send_byte(8'hA5, gaps);
    if (reload_mid) pulse_reload();
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    send_pay(pay_q.size(), gaps);
    send_byte(cs, gaps);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_case2_payload();
    pay_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  initial begin
    int          w0;
    logic [31:0] last_word;

    rst_i        = 1'b1;
    reload_i     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready",      64'(bus.rx_ready),   64'd1);
    check("rst_core_rst",      64'(core_rst),       64'd1);
    check("rst_system_active", 64'(system_active),  64'd0);
    check("rst_imem_we",       64'(bus.imem_we),    64'd0);
    check("rst_load_err",      64'(load_err),       64'd0);
    check("rst_words_loaded",  64'(words_loaded),   64'd0);
    rst_i = 1'b0;

    // Two-word frame
    load_case2_payload();
    send_frame(16'd2, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check("c2_mem0",          64'(mem[0]),        64'h0000_0013);
    check("c2_mem1",          64'(mem[1]),        64'h0010_0093);
    check("c2_words",         64'(words_loaded),  64'd2);
    check("c2_system_active", 64'(system_active), 64'd1);
    check("c2_core_rst",      64'(core_rst),      64'd0);
    check("c2_rx_ready",      64'(bus.rx_ready),  64'd0);
    check("c2_load_err",      64'(load_err),      64'd0);

    // Reload from DONE, then bad checksum
    pulse_reload();
    check("rl_system_active", 64'(system_active), 64'd0);
    check("rl_core_rst",      64'(core_rst),      64'd1);
    check("rl_rx_ready",      64'(bus.rx_ready),  64'd1);
    check("rl_words",         64'(words_loaded),  64'd0);
    send_frame(16'd2, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("c3_load_err",      64'(load_err),      64'd1);
    check("c3_core_rst",      64'(core_rst),      64'd1);
    check("c3_system_active", 64'(system_active), 64'd0);
    check("c3_rx_ready",      64'(bus.rx_ready),  64'd0);
    pulse_reload();
    check("c3_err_cleared",   64'(load_err),      64'd0);
    send_frame(16'd2, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check("c3_done_active",   64'(system_active), 64'd1);
    check("c3_done_err",      64'(load_err),      64'd0);

    // Junk before sync, random valid gaps, reload ignored mid-frame
    pulse_reload();
    mem[0] = 32'd0;
    mem[1] = 32'd0;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_frame(16'd2, 1'b0, 1'b1, 1'b1);
    wait_drain();
    check("c4_mem0",          64'(mem[0]),        64'h0000_0013);
    check("c4_mem1",          64'(mem[1]),        64'h0010_0093);
    check("c4_words",         64'(words_loaded),  64'd2);
    check("c4_system_active", 64'(system_active), 64'd1);

    // LEN == 0: straight to checksum
    pulse_reload();
    w0 = wr_count;
    pay_q = {};
    send_frame(16'd0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check("len0_active", 64'(system_active), 64'd1);
    check("len0_words",  64'(words_loaded),  64'd0);
    check("len0_writes", 64'(wr_count - w0), 64'd0);

    // LEN one past capacity
    pulse_reload();
    w0 = wr_count;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    @(negedge clk);
    check("c5_load_err", 64'(load_err),     64'd1);
    check("c5_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("c5_core_rst", 64'(core_rst),     64'd1);
    repeat (4) @(negedge clk);
    check("c5_no_write", 64'(wr_count - w0), 64'd0);

    // LEN == capacity fills memory exactly
    pulse_reload();
    pay_q = {};
    for (int i = 0; i < 4 * (1 << AW); i++) pay_q.push_back(8'($urandom));
    last_word = {pay_q[4095], pay_q[4094], pay_q[4093], pay_q[4092]};
    send_frame(16'h0400, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check("full_words",  64'(words_loaded),  64'd1024);
    check("full_active", 64'(system_active), 64'd1);
    check("full_last",   64'(mem[1023]),     64'(last_word));

    // Reset mid-payload after 6 bytes
    pulse_reload();
    load_case2_payload();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    w0 = wr_count;
    send_pay(6, 1'b0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    check("c6_one_write",  64'(wr_count - w0), 64'd1);
    check("c6_queue",      64'(exp_q.size()),  64'd0);
    check("c6_words",      64'(words_loaded),  64'd0);
    check("c6_rx_ready",   64'(bus.rx_ready),  64'd1);
    check("c6_core_rst",   64'(core_rst),      64'd1);
    mem[1] = 32'd0;
    send_frame(16'd2, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check("c6_mem0",   64'(mem[0]),        64'h0000_0013);
    check("c6_mem1",   64'(mem[1]),        64'h0010_0093);
    check("c6_words2", 64'(words_loaded),  64'd2);
    check("c6_active", 64'(system_active), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
